// File: rtl/ch_trigger_conditioner_pkg.sv
// Shared types for the channel trigger path: channel state, trigger FSM
// encoding and the sampling-gate decode used by both the conditioner and
// the channel state machine.
package ch_trigger_conditioner_pkg;

    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam int unsigned DEF_PULSE_LEN   = 4;
    localparam int unsigned DEF_WIDTH_W     = 4;
    localparam int unsigned DEF_HOLD_W      = 8;
    localparam int unsigned DEF_MISS_W      = 8;

    typedef enum logic [3:0] {
        INIT,
        SAMPLING_A,
        SAMPLING_B,
        SAMPLING_C,
        SAMPLING_D,
        SAMPLING_E,
        SAMPLING_A_AND_B,
        SAMPLING_C_AND_D,
        SAMPLING_ALL,
        STOPPED,
        READOUT
    } state_t;

    typedef enum logic [2:0] {
        TRG_IDLE,
        TRG_QUALIFY,
        TRG_FIRE,
        TRG_HOLDOFF,
        TRG_WAIT_LOW
    } trig_fsm_t;

    // True for channel states in which a trigger may advance sampling.
    // SAMPLING_E is deliberately excluded: it is a terminal capture phase.
    function automatic logic is_sampling_state(input state_t s);
        logic v;
        case (s)
            SAMPLING_A,
            SAMPLING_B,
            SAMPLING_C,
            SAMPLING_D,
            SAMPLING_A_AND_B,
            SAMPLING_C_AND_D,
            SAMPLING_ALL: v = 1'b1;
            default:      v = 1'b0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/ch_sync_edge.sv
// Multi-flop synchronizer for the asynchronous discriminator plus a
// registered rising-edge detector. o_disc_s and o_rise are aligned: when
// o_rise is high, o_disc_s is high in the same cycle.
module ch_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_disc,
    output logic o_disc_s,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_disc_q;
    logic                   r_rise;

    // Synchronizer chain, delayed level and edge flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync   <= '0;
            r_disc_q <= 1'b0;
            r_rise   <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], i_disc};
            r_disc_q <= r_sync[SYNC_STAGES-1];
            r_rise   <= r_sync[SYNC_STAGES-1] & ~r_disc_q;
        end
    end

    assign o_disc_s = r_disc_q;
    assign o_rise   = r_rise;

endmodule

// File: rtl/ch_trigger_conditioner.sv
// Per-channel trigger conditioner: synchronizes the discriminator, qualifies
// it by minimum width, emits a fixed-width registered trigger pulse, applies
// holdoff and re-arm, and counts edges that could not become triggers.
module ch_trigger_conditioner
    import ch_trigger_conditioner_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned PULSE_LEN   = DEF_PULSE_LEN,
    parameter int unsigned WIDTH_W     = DEF_WIDTH_W,
    parameter int unsigned HOLD_W      = DEF_HOLD_W,
    parameter int unsigned MISS_W      = DEF_MISS_W
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               DISC_IN,
    input  state_t             current_state,
    input  logic [WIDTH_W-1:0] MIN_WIDTH,
    input  logic [HOLD_W-1:0]  HOLDOFF,
    input  logic               MISS_CLR,
    output logic               trigger,
    output logic               armed,
    output logic [MISS_W-1:0]  missed_cnt
);

    localparam int unsigned PCNT_W = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;

    logic               w_disc_s;
    logic               w_rise;
    logic               w_gate_open;
    logic               w_miss_inc;

    trig_fsm_t          r_state;
    logic [WIDTH_W-1:0] r_wcnt;
    logic [WIDTH_W-1:0] r_min_w;
    logic [PCNT_W-1:0]  r_pcnt;
    logic [HOLD_W-1:0]  r_hcnt;
    logic               r_trigger;
    logic               r_armed;
    logic [MISS_W-1:0]  r_missed;

    ch_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .i_clk    (CLK),
        .i_rst    (RST),
        .i_disc   (DISC_IN),
        .o_disc_s (w_disc_s),
        .o_rise   (w_rise)
    );

    // Gate decode from the channel state machine.
    assign w_gate_open = is_sampling_state(current_state);

    // Edges lost to a closed gate, to a gate closing mid-qualify, or to holdoff.
    assign w_miss_inc = ((r_state == TRG_IDLE)    & w_rise & ~w_gate_open)
                      | ((r_state == TRG_QUALIFY) & w_disc_s & ~w_gate_open)
                      | ((r_state == TRG_HOLDOFF) & w_rise);

    // Trigger FSM with its counters and registered trigger/armed outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= TRG_IDLE;
            r_wcnt    <= '0;
            r_min_w   <= '0;
            r_pcnt    <= '0;
            r_hcnt    <= '0;
            r_trigger <= 1'b0;
            r_armed   <= 1'b0;
        end else begin
            r_armed <= (r_state == TRG_IDLE) & w_gate_open;
            case (r_state)
                TRG_IDLE: begin
                    if (w_rise && w_gate_open) begin
                        r_state <= TRG_QUALIFY;
                        r_wcnt  <= WIDTH_W'(1);
                        r_min_w <= (MIN_WIDTH == '0) ? WIDTH_W'(1) : MIN_WIDTH;
                    end
                end
                TRG_QUALIFY: begin
                    if (!w_disc_s) begin
                        r_state <= TRG_IDLE;
                    end else if (!w_gate_open) begin
                        r_state <= TRG_WAIT_LOW;
                    end else if (r_wcnt >= r_min_w) begin
                        r_state   <= TRG_FIRE;
                        r_pcnt    <= '0;
                        r_trigger <= 1'b1;
                    end else begin
                        r_wcnt <= r_wcnt + WIDTH_W'(1);
                    end
                end
                TRG_FIRE: begin
                    if (r_pcnt == PCNT_W'(PULSE_LEN - 1)) begin
                        r_trigger <= 1'b0;
                        r_hcnt    <= HOLDOFF;
                        r_state   <= (HOLDOFF == '0) ? TRG_WAIT_LOW : TRG_HOLDOFF;
                    end else begin
                        r_pcnt <= r_pcnt + PCNT_W'(1);
                    end
                end
                TRG_HOLDOFF: begin
                    if (r_hcnt <= HOLD_W'(1)) begin
                        r_state <= TRG_WAIT_LOW;
                    end else begin
                        r_hcnt <= r_hcnt - HOLD_W'(1);
                    end
                end
                TRG_WAIT_LOW: begin
                    if (!w_disc_s) begin
                        r_state <= TRG_IDLE;
                    end
                end
                default: begin
                    r_state   <= TRG_IDLE;
                    r_trigger <= 1'b0;
                end
            endcase
        end
    end

    // Saturating missed-edge counter; clear takes precedence over increment.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_missed <= '0;
        end else if (MISS_CLR) begin
            r_missed <= '0;
        end else if (w_miss_inc && (r_missed != {MISS_W{1'b1}})) begin
            r_missed <= r_missed + MISS_W'(1);
        end
    end

    assign trigger    = r_trigger;
    assign armed      = r_armed;
    assign missed_cnt = r_missed;

endmodule
